// File: rtl/vram_arbiter.sv
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Shares one synchronous 16 KB video RAM between the ULA video
//             fetch and the Z80 memory bus. Video fetch always wins. CPU
//             screen-page accesses are queued, issued in a free RAM cycle and
//             completed with a one-cycle ack pulse.
//  Options  : define VRAM_CONTENTION_EN to hold CPU accesses off while the
//             video block asserts its contention window (vid_cn).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
   parameter int         MEM_AW    = 14,
   parameter logic [1:0] BASE_PAGE = 2'b01
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              ce_i,
   input  logic              vid_rd_i,
   input  logic              vid_cn_i,
   input  logic [12:0]       vid_a_i,
   output logic [7:0]        vid_d_o,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [15:0]       cpu_a_i,
   input  logic [7:0]        cpu_di_i,
   output logic [7:0]        cpu_do_o,
   output logic              cpu_ack_o,
   output logic              cpu_wait_o,
   output logic [MEM_AW-1:0] mem_a_o,
   output logic              mem_we_o,
   output logic [7:0]        mem_d_o,
   input  logic [7:0]        mem_q_i
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MISS = 3'd1;
   localparam logic [2:0] S_PEND = 3'd2;
   localparam logic [2:0] S_CAP  = 3'd3;
   localparam logic [2:0] S_ACK  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              lat_we_q;
   logic [MEM_AW-1:0] lat_a_q;
   logic [7:0]        lat_di_q;
   logic [7:0]        cpu_do_q;
   logic              vid_sel_q;
   logic [7:0]        vid_d_q;
   logic [MEM_AW-1:0] mem_a_q, mem_a_d;
   logic              block;
   logic              issue;
   logic              cpu_hit;

   // The pixel strobe does not gate the RAM; the video block already qualifies rd.
`ifdef VRAM_CONTENTION_EN
   assign block = vid_cn_i;
   logic unused_ok;
   assign unused_ok = ce_i;
`else
   assign block = 1'b0;
   logic unused_ok;
   assign unused_ok = ce_i ^ vid_cn_i;
`endif

   assign cpu_hit  = (cpu_a_i[15:14] == BASE_PAGE);
   assign vid_d_o  = vid_d_q;
   assign cpu_do_o = cpu_do_q;
   assign mem_a_o  = mem_a_d;
   assign mem_d_o  = lat_di_q;

   // FSM state register
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_req_i) begin
               state_d = cpu_hit ? S_PEND : S_MISS;
            end
         end
         S_MISS:  state_d = S_ACK;
         S_PEND: begin
            if (issue) begin
               state_d = S_CAP;
            end
         end
         S_CAP:   state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs and RAM port steering; reset suppresses any RAM write or ack
   always_comb begin
      issue      = (state_q == S_PEND) && !vid_rd_i && !block && !reset_i;
      cpu_ack_o  = (state_q == S_ACK) && !reset_i;
      cpu_wait_o = ((state_q == S_PEND) || (state_q == S_CAP) ||
                    (state_q == S_MISS)) && !reset_i;
      mem_we_o   = issue && lat_we_q;
      if (vid_rd_i) begin
         mem_a_d = MEM_AW'(vid_a_i);
      end else if (issue) begin
         mem_a_d = lat_a_q;
      end else begin
         mem_a_d = mem_a_q;
      end
   end

   // Video fetch return path: the RAM answers one clock after the address
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         vid_sel_q <= 1'b0;
         vid_d_q   <= 8'h00;
         mem_a_q   <= '0;
      end else begin
         vid_sel_q <= vid_rd_i;
         mem_a_q   <= mem_a_d;
         if (vid_sel_q) begin
            vid_d_q <= mem_q_i;
         end
      end
   end

   // CPU request latch and read-data register
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         lat_we_q <= 1'b0;
         lat_a_q  <= '0;
         lat_di_q <= 8'h00;
         cpu_do_q <= 8'hFF;
      end else begin
         if ((state_q == S_IDLE) && cpu_req_i) begin
            lat_we_q <= cpu_we_i;
            lat_a_q  <= cpu_a_i[MEM_AW-1:0];
            lat_di_q <= cpu_di_i;
         end
         if ((state_q == S_MISS) && !lat_we_q) begin
            cpu_do_q <= 8'hFF;
         end
         if ((state_q == S_CAP) && !lat_we_q) begin
            cpu_do_q <= mem_q_i;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
//  Module   : tb_vram_arbiter
//  Purpose  : Self-checking bench for vram_arbiter with a 16 KB synchronous
//             RAM model. Table-driven CPU accesses plus hand sequences for
//             reset, video fetch, priority, contention and mid-op reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset, ce, vid_rd, vid_cn;
   logic [12:0] vid_a;
   logic [7:0]  vid_d;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_di, cpu_do;
   logic        cpu_ack, cpu_wait;
   logic [13:0] mem_a;
   logic        mem_we;
   logic [7:0]  mem_d, mem_q;

   logic [7:0]  ram [0:16383];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Synchronous RAM: one-cycle read latency, read-before-write
   always @(posedge clk) begin
      if (mem_we) ram[mem_a] <= mem_d;
      mem_q <= ram[mem_a];
   end

   vram_arbiter #(.MEM_AW(14), .BASE_PAGE(2'b01)) dut (
      .clock_i   (clk),
      .reset_i   (reset),
      .ce_i      (ce),
      .vid_rd_i  (vid_rd),
      .vid_cn_i  (vid_cn),
      .vid_a_i   (vid_a),
      .vid_d_o   (vid_d),
      .cpu_req_i (cpu_req),
      .cpu_we_i  (cpu_we),
      .cpu_a_i   (cpu_a),
      .cpu_di_i  (cpu_di),
      .cpu_do_o  (cpu_do),
      .cpu_ack_o (cpu_ack),
      .cpu_wait_o(cpu_wait),
      .mem_a_o   (mem_a),
      .mem_we_o  (mem_we),
      .mem_d_o   (mem_d),
      .mem_q_i   (mem_q)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Runs one CPU access with no video traffic; reports latency (negedges
   // after request until ack), read data, RAM write count and write address.
   task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] di,
                         output int lat, output logic [7:0] rdata,
                         output int nwe, output logic [13:0] wa);
      lat = -1; nwe = 0; wa = '0; rdata = 8'h00;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_di = di;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         #1;
         if (mem_we) begin
            nwe++;
            wa = mem_a;
         end
         if (cpu_ack) begin
            lat = k;
            rdata = cpu_do;
            cpu_req = 1'b0;
            break;
         end
      end
      if (lat < 0) cpu_req = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [15:0] a;
      logic [7:0]  di;
      int          exp_lat;
      logic [7:0]  exp_do;
      int          exp_nwe;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int          lat, nwe, bad, issue_k, ack_k, wait_n, exp_issue;
      logic [7:0]  rdata;
      logic [13:0] wa, last_a;

      vecs[0]  = '{1'b1, 16'h5800, 8'h3C, 3, 8'hFF, 1};
      vecs[1]  = '{1'b0, 16'h5800, 8'h00, 3, 8'h3C, 0};
      vecs[2]  = '{1'b0, 16'h8000, 8'h00, 2, 8'hFF, 0};
      vecs[3]  = '{1'b1, 16'h4123, 8'hA5, 3, 8'hFF, 1};
      vecs[4]  = '{1'b0, 16'h4123, 8'h00, 3, 8'hA5, 0};
      vecs[5]  = '{1'b1, 16'h4000, 8'h11, 3, 8'hA5, 1};
      vecs[6]  = '{1'b1, 16'h0000, 8'h77, 2, 8'hA5, 0};
      vecs[7]  = '{1'b0, 16'h4000, 8'h00, 3, 8'h11, 0};
      vecs[8]  = '{1'b1, 16'h7FFF, 8'h5A, 3, 8'h11, 1};
      vecs[9]  = '{1'b0, 16'h7FFF, 8'h00, 3, 8'h5A, 0};
      vecs[10] = '{1'b0, 16'hC000, 8'h00, 2, 8'hFF, 0};
      vecs[11] = '{1'b0, 16'h5800, 8'h00, 3, 8'h3C, 0};

      // Reset held two clocks with a request present
      reset = 1'b1; ce = 1'b1; vid_rd = 1'b0; vid_cn = 1'b0; vid_a = '0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 16'h5800; cpu_di = 8'h99;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk("rst_ack", cpu_ack, 1'b0);
         chk("rst_we", mem_we, 1'b0);
         chk("rst_do", cpu_do, 8'hFF);
         chk("rst_vid_d", vid_d, 8'h00);
         chk("rst_wait", cpu_wait, 1'b0);
         chk("rst_mem_a", mem_a, 14'h0000);
      end
      reset = 1'b0; cpu_req = 1'b0;

      // Table of CPU accesses, no video traffic
      last_a = 14'h0000;
      for (int i = 0; i < 12; i++) begin
         cpu_op(vecs[i].we, vecs[i].a, vecs[i].di, lat, rdata, nwe, wa);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_do", i), rdata, vecs[i].exp_do);
         chk($sformatf("v%0d_nwe", i), nwe, vecs[i].exp_nwe);
         if (vecs[i].exp_nwe != 0) chk($sformatf("v%0d_wa", i), wa, vecs[i].a[13:0]);
         if (vecs[i].a[15:14] == 2'b01) last_a = vecs[i].a[13:0];
         @(negedge clk);
         #1;
         chk($sformatf("v%0d_do_hold", i), cpu_do, vecs[i].exp_do);
         chk($sformatf("v%0d_a_hold", i), mem_a, last_a);
         chk($sformatf("v%0d_ack_once", i), cpu_ack, 1'b0);
      end

      // Video fetch of RAM[0x0123] (written A5 above)
      @(negedge clk);
      vid_rd = 1'b1; vid_a = 13'h0123;
      #1;
      chk("vid_mem_a", mem_a, 14'h0123);
      chk("vid_we", mem_we, 1'b0);
      @(negedge clk);
      vid_rd = 1'b0;
      #1;
      chk("vid_d_pre", vid_d, 8'h00);
      @(negedge clk);
      #1;
      chk("vid_d", vid_d, 8'hA5);

      // Priority: CPU write held off for 8 video cycles
      @(negedge clk);
      vid_rd = 1'b1; vid_a = 13'h0123;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 16'h4456; cpu_di = 8'h77;
      bad = 0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         #1;
         if (mem_we !== 1'b0 || mem_a !== 14'h0123 || cpu_wait !== 1'b1 || cpu_ack !== 1'b0) bad++;
      end
      chk("prio_blocked", bad, 0);
      @(negedge clk);
      vid_rd = 1'b0;
      #1;
      chk("prio_issue_we", mem_we, 1'b1);
      chk("prio_issue_a", mem_a, 14'h0456);
      chk("prio_vid_d", vid_d, 8'hA5);
      @(negedge clk);
      #1;
      chk("prio_we_once", mem_we, 1'b0);
      @(negedge clk);
      #1;
      chk("prio_ack", cpu_ack, 1'b1);
      cpu_req = 1'b0;
      chk("prio_ram", ram[14'h0456], 8'h77);

      // Contention window of 12 clocks with no video fetch
      @(negedge clk);
      vid_cn = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 16'h4800; cpu_di = 8'hC3;
      issue_k = -1; ack_k = -1; wait_n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 12) vid_cn = 1'b0;
         #1;
         if (issue_k < 0 && cpu_wait) wait_n++;
         if (mem_we && issue_k < 0) issue_k = k;
         if (cpu_ack) begin
            ack_k = k;
            cpu_req = 1'b0;
            break;
         end
      end
      cpu_req = 1'b0; vid_cn = 1'b0;
`ifdef VRAM_CONTENTION_EN
      exp_issue = 12;
`else
      exp_issue = 1;
`endif
      chk("cn_issue", issue_k, exp_issue);
      chk("cn_ack", ack_k, exp_issue + 2);
      chk("cn_wait", wait_n, exp_issue);
      chk("cn_ram", ram[14'h0800], 8'hC3);

      // Reset while a write is pending behind video
      @(negedge clk);
      vid_rd = 1'b1; vid_a = 13'h0010;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 16'h4789; cpu_di = 8'hE1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      vid_rd = 1'b0; reset = 1'b1;
      #1;
      chk("mid_rst_we", mem_we, 1'b0);
      chk("mid_rst_ack", cpu_ack, 1'b0);
      @(negedge clk);
      reset = 1'b0; cpu_req = 1'b0;
      #1;
      chk("mid_rst_wait", cpu_wait, 1'b0);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         if (mem_we !== 1'b0 || cpu_ack !== 1'b0) bad++;
      end
      chk("mid_rst_quiet", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
